fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle controller that sequences instruction fetch for the single-issue CPU.
- Owns the PC register and the next-PC selection: sequential PC+4, or PC+4+(offset<<2) when branch and zero are both set.
- Runs the instruction-memory request/ready handshake and latches the instruction register.
- Gives the datapath one execute slot per instruction, which can be stalled.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset
- ADDR_W, 32, PC / address width (the block is specified and verified at 32 only)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; takes effect on the rising clock edge while high
- start  in  1  leave IDLE and begin fetching at the current PC
- halt  in  1  sampled in EXEC; return to IDLE after the PC update
- stall  in  1  downstream hold; freezes EXEC
- branch  in  1  current instruction is a conditional branch (B)
- zero  in  1  ALU zero flag for the current instruction (Z)
- branch_off  in  32  sign-extended word offset from the current instruction
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- imem_ready  in  1  memory data valid this cycle
- imem_data  in  32  instruction word
- ir  out  32  latched instruction register
- ir_valid  out  1  one-cycle pulse when ir is loaded
- exec_slot  out  1  high while in EXEC (datapath may commit)
- pc  out  32  current PC

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0
  - ir_valid=0, imem_req=0, imem_addr=RESET_PC, exec_slot=0
  - Reset overrides every other input, including mid-handshake. A ready arriving in the reset cycle is dropped.
- States: IDLE, REQ, EXEC.
- IDLE:
  - imem_req=0.
  - start=1 -> REQ next cycle.
- REQ:
  - imem_req=1; imem_addr=pc, held stable until ready.
  - imem_ready=0 -> stay in REQ (no timeout).
  - imem_ready=1 -> ir<=imem_data and ir_valid=1 for the following cycle only; go to EXEC.
  - Minimum latency: start to first ir_valid is 2 cycles with zero-wait memory.
- EXEC:
  - exec_slot=1, imem_req=0.
  - stall=1 -> remain in EXEC; pc, ir and state unchanged; branch/zero ignored.
  - stall=0 -> pc <= (branch & zero) ? pc+4+(branch_off<<2) : pc+4.
  - After the update, halt=1 -> IDLE; otherwise -> REQ.
  - halt together with stall=1 is ignored until stall drops.
- Arithmetic:
  - All additions are modulo 2^32, with silent wrap. Example: pc=32'hFFFFFFFC sequential -> 32'h00000000.
  - The shift of branch_off discards the top 2 bits. A negative offset yields a backward target.
- Throughput: 2 cycles per instruction with zero-wait memory and no stall.
- start outside IDLE is ignored. halt outside EXEC is ignored and not remembered.
- imem_data is ignored unless state=REQ and imem_ready=1.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch [31:0] and perf_taken [31:0], both reset to 0.
  - perf_fetch increments on every ir load; perf_taken increments on every taken-branch PC update.
  - Both wrap at 2^32 and are frozen while stall=1.
- FETCH_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then start=1, zero-wait memory returning 32'h20080005 at address 0:
  - imem_req high with addr 0.
  - ir=32'h20080005, ir_valid pulses once.
  - pc becomes 4 after EXEC; next request at addr 4.
- Taken branch: pc=8, branch=1, zero=1, branch_off=32'hFFFFFFFE -> next pc=32'h00000004.
- Not taken: pc=8, branch=1, zero=0, branch_off=3 -> pc=12.
- Wait states: hold imem_ready=0 for 3 cycles -> imem_req and imem_addr stable throughout; ir unchanged until ready; a single ir_valid pulse follows.
- Stall then halt:
  - stall=1 for 4 cycles in EXEC -> pc frozen, exec_slot high.
  - Release with halt=1 -> pc updates once, then IDLE with imem_req=0.
- Reset while in REQ awaiting ready -> IDLE, pc=RESET_PC, ir_valid stays 0.
- With FETCH_PERF_EN: 5 fetches including 2 taken branches -> perf_fetch=5, perf_taken=2.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake, and issues one execute slot per instruction.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic              i_zero,
    input  logic [ADDR_W-1:0] i_branch_off,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_ir,
    output logic              o_ir_valid,
    output logic              o_exec_slot,
`ifdef FETCH_PERF_EN
    output logic [31:0]       o_perf_fetch,
    output logic [31:0]       o_perf_taken,
`endif
    output logic [ADDR_W-1:0] o_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_ir_valid;
    logic              w_load;
    logic              w_advance;
    logic              w_taken;
    logic [ADDR_W-1:0] w_pc_next;

    // Offset is a word count; the two bits shifted out of the top are dropped.
    assign w_taken   = i_branch & i_zero;
    assign w_pc_next = w_taken ? r_pc + ADDR_W'(4) + {i_branch_off[ADDR_W-3:0], 2'b00}
                               : r_pc + ADDR_W'(4);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        o_imem_req   = 1'b0;
        o_exec_slot  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_next = REQ;
            end
            REQ: begin
                o_imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_load       = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                o_exec_slot = 1'b1;
                if (!i_stall) begin
                    w_advance    = 1'b1;
                    w_state_next = i_halt ? IDLE : REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ir_valid <= w_load;
            if (w_load)    r_ir <= i_imem_data;
            if (w_advance) r_pc <= w_pc_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_taken;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_fetch <= '0;
            r_perf_taken <= '0;
        end else if (!i_stall) begin
            if (w_load)              r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_advance && w_taken) r_perf_taken <= r_perf_taken + 32'd1;
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_taken = r_perf_taken;
`endif

    // The request address is the PC itself, which cannot move outside EXEC.
    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_ir_valid  = r_ir_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random traffic against a phase-level model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, start, halt, stall, branch, zero, imem_ready;
    logic [31:0] branch_off, imem_data;
    logic        imem_req, ir_valid, exec_slot;
    logic [31:0] imem_addr, ir, pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_taken;
`endif

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = idle, 1 = waiting on memory, 2 = execute slot.
    int          m_phase;
    logic [31:0] m_pc, m_ir;
    logic        m_irv;
    logic [31:0] m_fetch, m_taken;

    always #5 clock = ~clock;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_halt(halt),
        .i_stall(stall), .i_branch(branch), .i_zero(zero), .i_branch_off(branch_off),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ready(imem_ready),
        .i_imem_data(imem_data), .o_ir(ir), .o_ir_valid(ir_valid), .o_exec_slot(exec_slot),
`ifdef FETCH_PERF_EN
        .o_perf_fetch(perf_fetch), .o_perf_taken(perf_taken),
`endif
        .o_pc(pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; halt = 0; stall = 0; branch = 0; zero = 0;
        branch_off = 0; imem_ready = 0; imem_data = 0;
    endtask

    // Advance the model from the inputs currently driven, clock once, then compare everything.
    task automatic tick();
        logic [31:0] target;
        if (reset) begin
            m_phase = 0; m_pc = RESET_PC; m_ir = 0; m_irv = 0; m_fetch = 0; m_taken = 0;
        end else begin
            m_irv = 0;
            if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase == 1) begin
                if (imem_ready) begin
                    m_ir = imem_data; m_irv = 1; m_phase = 2;
                    if (!stall) m_fetch = m_fetch + 1;
                end
            end else if (!stall) begin
                target = m_pc + 4;
                if (branch && zero) begin
                    target = target + branch_off * 4;
                    m_taken = m_taken + 1;
                end
                m_pc = target;
                m_phase = halt ? 0 : 1;
            end
        end
        @(posedge clock);
        #1;
        check("pc", pc, m_pc);
        check("ir", ir, m_ir);
        check("ir_valid", {31'd0, ir_valid}, {31'd0, m_irv});
        check("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
        check("imem_addr", imem_addr, m_pc);
        check("exec_slot", {31'd0, exec_slot}, {31'd0, m_phase == 2});
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_taken", perf_taken, m_taken);
`endif
    endtask

    // One zero-wait instruction: fetch from REQ, then a single unstalled EXEC.
    task automatic run_instr(input logic [31:0] word, input logic br, input logic z,
                             input logic [31:0] off, input logic hlt);
        idle_inputs(); imem_ready = 1; imem_data = word; tick();
        idle_inputs(); branch = br; zero = z; branch_off = off; halt = hlt; tick();
    endtask

    initial begin
        idle_inputs(); reset = 1;
        m_phase = 0; m_pc = RESET_PC; m_ir = 0; m_irv = 0; m_fetch = 0; m_taken = 0;
        tick(); tick();
        idle_inputs(); tick();
        check("reset_pc", pc, 32'h0);

        // First fetch at address 0, then two more sequential-ish instructions to reach pc=8.
        start = 1; tick();
        check("first_req_addr", imem_addr, 32'h0);
        run_instr(32'h2008_0005, 0, 0, 0, 0);
        check("pc_after_first", pc, 32'h4);
        check("second_req_addr", imem_addr, 32'h4);
        run_instr(32'h1111_1111, 0, 0, 0, 0);
        check("pc_before_taken", pc, 32'h8);
        run_instr(32'h2222_2222, 1, 1, 32'hFFFF_FFFE, 0);
        check("taken_back", pc, 32'h4);
        run_instr(32'h3333_3333, 1, 0, 32'h0000_0007, 0);
        check("seq_to_8", pc, 32'h8);
        run_instr(32'h4444_4444, 1, 0, 32'h0000_0003, 0);
        check("not_taken", pc, 32'hC);
`ifdef FETCH_PERF_EN
        check("perf5_fetch", perf_fetch, 32'd5);
        check("perf5_taken", perf_taken, 32'd1);
        run_instr(32'h5555_5555, 1, 1, 32'h0000_0000, 0);
        check("perf_taken2", perf_taken, 32'd2);
`endif

        // Three wait states, then a single ir_valid pulse.
        idle_inputs(); imem_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        imem_ready = 1; imem_data = 32'hCAFE_0001; tick();
        check("wait_ir", ir, 32'hCAFE_0001);

        // Stall four cycles with halt and a branch pending, then release with halt.
        idle_inputs(); stall = 1; halt = 1; branch = 1; zero = 1; branch_off = 32'h10;
        repeat (4) tick();
        idle_inputs(); halt = 1; tick();
        check("halt_idle_req", {31'd0, imem_req}, 32'd0);
        idle_inputs(); halt = 1; repeat (2) tick();

        // Reset while awaiting ready; a ready in the reset cycle is dropped.
        start = 1; tick();
        idle_inputs(); repeat (2) tick();
        reset = 1; imem_ready = 1; imem_data = 32'h0BAD_0BAD; tick();
        check("reset_in_req_irv", {31'd0, ir_valid}, 32'd0);
        idle_inputs(); tick();

        // Wrap test: push the PC to FFFFFFFC via a taken branch, then step sequentially.
        start = 1; tick();
        run_instr(32'h6, 1, 1, 32'h3FFF_FFFE, 0);
        check("pc_near_top", pc, 32'hFFFF_FFFC);
        run_instr(32'h7, 0, 0, 0, 0);
        check("pc_wrap", pc, 32'h0);

        // Random traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            start      = $urandom_range(0, 1);
            halt       = ($urandom_range(0, 5) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            branch     = $urandom_range(0, 1);
            zero       = $urandom_range(0, 1);
            branch_off = $urandom;
            imem_ready = $urandom_range(0, 1);
            imem_data  = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
